// File: rtl/vscpu_mem_responder.sv
// vscpu_mem_responder: 1-cycle-latency RAM for VerySimpleCPU with byte-serial boot loader.
// Define VSCPU_MMIO_EN to map the top word to a 32-bit GPIO port.
module vscpu_mem_responder #(
    parameter int SIZE = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wrEn,
    input  logic [SIZE-1:0] addr_toRAM,
    input  logic [31:0]     data_toRAM,
    output logic [31:0]     data_fromRAM,
    output logic            cpu_rst,
    input  logic            ld_valid,
    input  logic [7:0]      ld_byte,
    input  logic            ld_last,
    output logic            ld_ready,
    input  logic            ld_req,
    output logic            ld_ovf,
    input  logic [31:0]     gpio_in,
    output logic [31:0]     gpio_out
);
    typedef enum logic [1:0] {BOOT, LOAD, DONE, RUN} state_t;
    state_t state;
    logic [31:0]     mem [0:2**SIZE-1];
    logic [1:0]      bcnt;
    logic [SIZE-1:0] wcnt;
    logic            wrapped;
    logic [31:0]     asm_word;
    logic            run, ld_fire, ld_wr, cpu_wr, is_io;
    logic [31:0]     lw, rd;
    assign run     = state == RUN;
    assign is_io   = addr_toRAM == {SIZE{1'b1}};
    assign ld_fire = state == LOAD && ld_valid && ld_ready;
    assign ld_wr   = ld_fire && (bcnt == 2'd3 || ld_last);
    // asm_word holds only the bytes received so far, so upper bytes of a short word stay zero
    assign lw      = asm_word | (32'(ld_byte) << {bcnt, 3'b000});
`ifdef VSCPU_MMIO_EN
    assign cpu_wr = run && wrEn && !is_io;
    assign rd     = is_io ? gpio_in : mem[addr_toRAM];
    always_ff @(posedge clk or posedge rst)
        if (rst)
            gpio_out <= '0;
        else if (run && wrEn && is_io)
            gpio_out <= data_toRAM;
`else
    logic unused_gpio;
    assign unused_gpio = ^{gpio_in, is_io};
    assign cpu_wr      = run && wrEn;
    assign rd          = mem[addr_toRAM];
    assign gpio_out    = '0;
`endif
    always_ff @(posedge clk)
        if (ld_wr)
            mem[wcnt] <= lw;
        else if (cpu_wr)
            mem[addr_toRAM] <= data_toRAM;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state        <= BOOT;
            cpu_rst      <= 1'b1;
            ld_ready     <= 1'b0;
            data_fromRAM <= '0;
            ld_ovf       <= 1'b0;
            bcnt         <= '0;
            wcnt         <= '0;
            wrapped      <= 1'b0;
            asm_word     <= '0;
        end else begin
            data_fromRAM <= run ? rd : '0;
            case (state)
                BOOT: begin
                    bcnt     <= '0;
                    wcnt     <= '0;
                    wrapped  <= 1'b0;
                    asm_word <= '0;
                    ld_ready <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: if (ld_fire) begin
                    bcnt     <= ld_wr ? 2'd0 : bcnt + 2'd1;
                    asm_word <= ld_wr ? '0 : lw;
                    if (ld_wr) begin
                        wcnt <= wcnt + SIZE'(1);
                        if (&wcnt) wrapped <= 1'b1;
                        if (wcnt == '0 && wrapped) ld_ovf <= 1'b1;
                    end
                    if (ld_last) begin
                        state    <= DONE;
                        ld_ready <= 1'b0;
                    end
                end
                DONE: begin
                    state   <= RUN;
                    cpu_rst <= 1'b0;
                end
                RUN: if (ld_req) begin
                    state   <= BOOT;
                    cpu_rst <= 1'b1;
                end
                default: state <= BOOT;
            endcase
        end
endmodule

// File: doc/vscpu_mem_responder.md
# vscpu_mem_responder

Memory-side responder for the VerySimpleCPU RAM interface. It serves the CPU's single-port read/write requests with the one-cycle read latency the CPU's fetch/operand states require. It also contains a byte-serial boot loader that fills RAM while holding the CPU in reset. Optionally, it maps the top word of the address space to a 32-bit I/O port.

## Interface
- SIZE, 14, address width in words; depth = 2**SIZE words of 32 bits
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wrEn  in  1  CPU write enable
- addr_toRAM  in  SIZE  CPU word address
- data_toRAM  in  32  CPU write data
- data_fromRAM  out  32  read data, registered
- cpu_rst  out  1  reset to CPU, registered, active-high
- ld_valid  in  1  loader byte valid
- ld_byte  in  8  loader byte
- ld_last  in  1  qualifies final byte of image
- ld_ready  out  1  loader can accept a byte, registered
- ld_req  in  1  request reload, sampled only in RUN
- ld_ovf  out  1  sticky: image exceeded depth
- gpio_in  in  32  MMIO input port
- gpio_out  out  32  MMIO output register

## Operation
- States:
  - BOOT: 1 cycle; clears byte and word counters; next LOAD.
  - LOAD: ld_ready=1; bytes accepted on ld_valid&ld_ready.
  - DONE: 1 cycle; ld_ready=0; next RUN.
  - RUN: cpu_rst=0; CPU port active.
- Reset values: state BOOT, cpu_rst=1, ld_ready=0, data_fromRAM=0, gpio_out=0, ld_ovf=0, counters 0.
- Byte assembly is little-endian: byte 0 goes to [7:0], byte 3 to [31:24].
  - On acceptance of the 4th byte, the word is written to mem[wcnt] on the same edge; wcnt increments.
- ld_last on byte k (k=0..3) writes the partial word with the unfilled upper bytes zero; next state DONE.
- wcnt wraps from 2**SIZE-1 to 0. A write at wcnt=0 after a wrap sets ld_ovf (cleared only by rst).
- RUN:
  - Every edge: data_fromRAM <= mem[addr_toRAM].
  - If wrEn: mem[addr_toRAM] <= data_toRAM.
  - Read-during-write to the same address returns the old data.
- ld_req=1 in RUN: next state BOOT, and cpu_rst=1 from the next edge. Memory contents are preserved until overwritten.
- ld_req is ignored in BOOT/LOAD/DONE.
- In BOOT/LOAD/DONE:
  - CPU wrEn is ignored; no memory write occurs from the CPU port.
  - data_fromRAM <= 0.
- Async reset mid-load: returns to BOOT immediately. Partially assembled bytes are discarded; already-written words remain.

## Timing
- Read latency is exactly 1 cycle: address presented in cycle n, data valid in cycle n+1. This matches the CPU issuing addr_toRAM in one state and consuming data_fromRAM in the next.
- Write takes effect at the edge where wrEn=1; a read of that address in the following cycle returns the new data.
- Loader handshake completes at the edge where ld_valid&ld_ready=1. ld_ready stays 1 through LOAD, so one byte per cycle is sustainable.
- Last-byte handshake at edge E:
  - state DONE in cycle E..E+1;
  - cpu_rst falls at edge E+1;
  - CPU's first fetch of address 0 occurs after its own reset state.
- ld_req seen at edge E: cpu_rst=1 after E, BOOT in E..E+1, ld_ready=1 after E+1.
- gpio_out updates at the write edge; gpio_in is sampled at the read edge.

## Configuration
- VSCPU_MMIO_EN defined: address 2**SIZE-1 is the MMIO port.
  - CPU writes to it load gpio_out and do not modify memory.
  - CPU reads from it return gpio_in.
  - The loader still writes the memory word at that address, which the CPU cannot see.
- VSCPU_MMIO_EN undefined: address 2**SIZE-1 is ordinary RAM; gpio_out is constant 0 and gpio_in is unused.

## Test plan
- Reset, then bytes 0x78,0x56,0x34,0x12 with ld_last on the 4th -> mem[0]=0x12345678, cpu_rst falls one cycle after the last handshake, ld_ready=0 in RUN.
- Load 3 bytes 0xAA,0xBB,0xCC with ld_last on the 3rd -> mem[0]=0x00CCBBAA.
- RUN: write 0xDEADBEEF to addr 5, then read addr 5 next cycle -> data_fromRAM=0xDEADBEEF one cycle after the address is presented. Read-during-write to addr 5 with new data 0x1 returns 0xDEADBEEF.
- With VSCPU_MMIO_EN: write 0x0000_00FF to 0x3FFF -> gpio_out=0xFF; with gpio_in=0x1234, a read of 0x3FFF -> 0x1234. Without the macro, the same sequence reads back 0xFF and gpio_out stays 0.
- Pulse ld_req in RUN -> cpu_rst=1 next cycle; CPU wrEn=1 during LOAD leaves memory unchanged; ld_req pulsed during LOAD has no effect.
- With SIZE=2, stream 20 bytes -> words wrap, ld_ovf=1 on the 5th word write, mem[0] holds bytes 16..19. Assert rst mid-word -> state BOOT, ld_ready=0 and cpu_rst=1 immediately.
